// File: rtl/pcs_rx_unpack_mc_if.sv
// FIFO-side and sink-side signal bundle for pcs_rx_unpack_mc.
// The slave modport is the unpacker's view; master is the driver/sink view.
interface pcs_rx_unpack_mc_if #(
    parameter int unsigned P_DATA_W   = 64,
    parameter int unsigned P_AUX_CH   = 4,
    parameter int unsigned P_PARA_NUM = 9
);
    logic                    i_data_valid;
    logic                    i_pcs_head;
    logic [P_DATA_W-1:0]     i_pcs_data;
    logic                    i_empty;
    logic                    o_data_rd_en;
    logic                    o_syn;
    logic                    o_frame_err;
    logic                    o_video_vsyn;
    logic                    o_video_lock;
    logic                    o_video_de;
    logic [P_DATA_W-1:0]     o_video_data;
    logic [P_AUX_CH-1:0]     o_aux_en;
    logic [P_AUX_CH-1:0]     o_aux_valid;
    logic [P_DATA_W-1:0]     o_aux_data;
    logic [P_PARA_NUM*16-1:0] o_para_table;

    modport master (
        output i_data_valid, i_pcs_head, i_pcs_data, i_empty,
        input  o_data_rd_en, o_syn, o_frame_err, o_video_vsyn, o_video_lock, o_video_de,
               o_video_data, o_aux_en, o_aux_valid, o_aux_data, o_para_table
    );

    modport slave (
        input  i_data_valid, i_pcs_head, i_pcs_data, i_empty,
        output o_data_rd_en, o_syn, o_frame_err, o_video_vsyn, o_video_lock, o_video_de,
               o_video_data, o_aux_en, o_aux_valid, o_aux_data, o_para_table
    );
endinterface

// File: rtl/pcs_rx_unpack_mc.sv
// PCS RX frame unpacker: 0xFB header alignment, lock/flywheel FSM, video/aux/parameter demux.
// Define PCS_RX_CHECKSUM_EN to include the per-frame byte-sum checksum in the frame verdict.
module pcs_rx_unpack_mc #(
    parameter int unsigned P_DATA_W      = 64,
    parameter int unsigned P_FRAME_LEN   = 528,
    parameter int unsigned P_VALID_LEN   = 512,
    parameter int unsigned P_VID_START   = 8,
    parameter int unsigned P_VID_LEN     = 480,
    parameter int unsigned P_AUX_CH      = 4,
    parameter int unsigned P_PARA_NUM    = 9,
    parameter int unsigned P_LOCK_FRAMES = 3,
    parameter int unsigned P_LOSS_FRAMES = 2
) (
    input logic               i_pcs_clk,
    input logic               i_rst,
    pcs_rx_unpack_mc_if.slave bus
);
    localparam int unsigned CW = $clog2(P_FRAME_LEN + 1);
    localparam int unsigned GW = $clog2(P_LOCK_FRAMES + 1);
    localparam int unsigned BW = $clog2(P_LOSS_FRAMES + 1);
    localparam logic [CW-1:0] VALID_LEN  = CW'(P_VALID_LEN);
    localparam logic [CW-1:0] FRAME_LAST = CW'(P_FRAME_LEN - 1);
    localparam logic [CW-1:0] VID_FIRST  = CW'(P_VID_START);
    localparam logic [CW-1:0] VID_END    = CW'(P_VID_START + P_VID_LEN);

    typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0]       good_cnt_q, good_cnt_d;
    logic [BW-1:0]       bad_cnt_q, bad_cnt_d;
    logic                in_valid, accept, is_head, at_zero;
    logic                verdict, good, commit, to_hunt, locked, data_word, vid_hit, cks_ok;
    logic [P_AUX_CH-1:0] aux_hit;

    logic                    err_q, vsyn_q, vlock_q, video_ready_q, de_q;
    logic [P_AUX_CH-1:0]     aux_en_q, aux_valid_q;
    logic [P_DATA_W-1:0]     video_data_q, aux_data_q;
    logic [7:0]              sh_idx_q;
    logic [15:0]             sh_val_q;
    logic [P_PARA_NUM*16-1:0] para_q;

    assign in_valid  = cnt_q < VALID_LEN;
    assign accept    = bus.i_data_valid & in_valid;
    assign is_head   = bus.i_pcs_head & (bus.i_pcs_data[7:0] == 8'hFB);
    assign at_zero   = (cnt_q == '0);
    assign cnt_inc   = (cnt_q == FRAME_LAST) ? '0 : cnt_q + CW'(1);
    assign locked    = (state_q == StLocked);
    // A verdict is taken at the expected header slot, or when a header shows up out of place.
    assign verdict   = accept & (state_q != StHunt) & (at_zero | is_head);
    assign good      = verdict & at_zero & is_head & cks_ok;
    assign data_word = accept & (state_q != StHunt) & ~at_zero & ~is_head;
    assign vid_hit   = data_word & locked & video_ready_q & (cnt_q >= VID_FIRST) &
                       (cnt_q < VID_END);
    assign to_hunt   = (state_q != StHunt) & (state_d == StHunt);

    always_comb begin
        aux_hit = '0;
        for (int k = 0; k < P_AUX_CH; k++) begin
            aux_hit[k] = data_word & locked & aux_en_q[k] & (cnt_q == CW'(2 + k));
        end
    end

`ifdef PCS_RX_CHECKSUM_EN
    localparam logic [CW-1:0] CKS_IDX = CW'(P_VALID_LEN - 1);
    logic [7:0] sum_q;
    logic       cks_bad_q;
    logic       frame_start;

    function automatic logic [7:0] byte_sum(input logic [P_DATA_W-1:0] w);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < P_DATA_W / 8; i++) begin
            s = s + w[8*i+:8];
        end
        return s;
    endfunction

    assign frame_start = accept & ((state_q == StHunt) ? is_head : (at_zero | is_head));

    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q     <= '0;
            cks_bad_q <= 1'b0;
        end else if (frame_start) begin
            sum_q     <= byte_sum(bus.i_pcs_data);
            cks_bad_q <= 1'b0;
        end else if (accept && cnt_q == CKS_IDX) begin
            cks_bad_q <= (bus.i_pcs_data[7:0] != sum_q);
        end else if (accept) begin
            sum_q <= sum_q + byte_sum(bus.i_pcs_data);
        end
    end

    assign cks_ok = ~cks_bad_q;
`else
    assign cks_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        commit     = 1'b0;
        case (state_q)
            StHunt: begin
                cnt_d = '0;
                if (accept && is_head) begin
                    state_d    = StCheck;
                    cnt_d      = CW'(1);
                    good_cnt_d = GW'(1);
                end
            end
            StCheck: begin
                if (verdict) begin
                    if (good) begin
                        cnt_d = CW'(1);
                        if (good_cnt_q >= GW'(P_LOCK_FRAMES - 1)) begin
                            state_d   = StLocked;
                            bad_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                    end else begin
                        state_d = StHunt;
                        cnt_d   = '0;
                    end
                end else if (accept || !in_valid) begin
                    cnt_d = cnt_inc;
                end
            end
            StLocked: begin
                if (verdict) begin
                    // Flywheel and realign both restart the frame at word 1.
                    cnt_d = CW'(1);
                    if (good) begin
                        bad_cnt_d = '0;
                        commit    = 1'b1;
                    end else if (bad_cnt_q >= BW'(P_LOSS_FRAMES - 1)) begin
                        state_d = StHunt;
                        cnt_d   = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BW'(1);
                    end
                end else if (accept || !in_valid) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StHunt;
            cnt_q      <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q         <= 1'b0;
            vsyn_q        <= 1'b0;
            vlock_q       <= 1'b0;
            video_ready_q <= 1'b0;
            aux_en_q      <= '0;
            de_q          <= 1'b0;
            aux_valid_q   <= '0;
            video_data_q  <= '0;
            aux_data_q    <= '0;
            sh_idx_q      <= '0;
            sh_val_q      <= '0;
            para_q        <= '0;
        end else begin
            err_q <= verdict & ~good;
            if (to_hunt) begin
                vsyn_q        <= 1'b0;
                vlock_q       <= 1'b0;
                video_ready_q <= 1'b0;
                aux_en_q      <= '0;
                de_q          <= 1'b0;
                aux_valid_q   <= '0;
                para_q        <= '0;
            end else begin
                de_q        <= vid_hit;
                aux_valid_q <= aux_hit;
                if (data_word && cnt_q == CW'(1)) begin
                    video_ready_q <= bus.i_pcs_data[0];
                    vsyn_q        <= bus.i_pcs_data[1];
                    vlock_q       <= bus.i_pcs_data[2];
                    aux_en_q      <= bus.i_pcs_data[3+:P_AUX_CH];
                    sh_idx_q      <= bus.i_pcs_data[23:16];
                    sh_val_q      <= bus.i_pcs_data[39:24];
                end
                // Out-of-range indices match no entry and are dropped.
                for (int i = 0; i < P_PARA_NUM; i++) begin
                    if (commit && sh_idx_q == 8'(i)) begin
                        para_q[16*i+:16] <= sh_val_q;
                    end
                end
            end
            if (vid_hit) begin
                video_data_q <= bus.i_pcs_data;
            end
            if (|aux_hit) begin
                aux_data_q <= bus.i_pcs_data;
            end
        end
    end

    assign bus.o_data_rd_en = in_valid & ~bus.i_empty;
    assign bus.o_syn        = locked;
    assign bus.o_frame_err  = err_q;
    assign bus.o_video_vsyn = vsyn_q;
    assign bus.o_video_lock = vlock_q;
    assign bus.o_video_de   = de_q;
    assign bus.o_video_data = video_data_q;
    assign bus.o_aux_en     = aux_en_q;
    assign bus.o_aux_valid  = aux_valid_q;
    assign bus.o_aux_data   = aux_data_q;
    assign bus.o_para_table = para_q;
endmodule
